// File: rtl/pmem_burst_responder.sv
// pmem_burst_responder
//   Memory endpoint for the 64-bit line burst protocol. It accepts one
//   256-bit line read or write at a time. After a fixed latency it answers
//   with four consecutive 64-bit beats, lowest qword first. Storage is an
//   internal line array, and reset does not clear it.
//
// Parameters
//   DEPTH_LINES  lines stored (power of 2, >= 2); address wraps modulo
//                DEPTH_LINES*32 bytes
//   LATENCY      cycles from request acceptance to first beat (>= 1)
//
// Ports
//   clk           clock
//   rst           synchronous, active-high reset
//   pmem_read     line read request, held until the cycle after the last beat
//   pmem_write    line write request, held until the cycle after the last beat
//   pmem_address  byte address; bits [4:0] ignored
//   pmem_wdata    write beat, sampled in each write resp cycle
//   pmem_resp     beat valid/accepted, high for 4 consecutive cycles
//   pmem_rdata    registered read beat; holds its value outside resp cycles
//   proto_err     sticky protocol-violation flag (PMEM_PROTO_CHECK_EN only)
//
// Build option
//   PMEM_PROTO_CHECK_EN  when defined, adds proto_err and the checker that
//                        drives it. Otherwise violations are handled silently:
//                        read wins, and the latched line/op are used.

module pmem_burst_responder #(
   parameter int unsigned DEPTH_LINES = 256,
   parameter int unsigned LATENCY     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pmem_read,
   input  logic        pmem_write,
   input  logic [31:0] pmem_address,
   input  logic [63:0] pmem_wdata,
   output logic        pmem_resp,
   output logic [63:0] pmem_rdata
`ifdef PMEM_PROTO_CHECK_EN
   ,
   output logic        proto_err
`endif
);

   localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [31:0] ADDR_USED_MASK = ((32'd1 << IDX_W) - 32'd1) << 5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_BURST = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q;
   logic [IDX_W-1:0]   line_q;
   logic               op_rd_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [1:0]         beat_q;
   logic               resp_q;
   logic [63:0]        rdata_q;

   // The array is organised as qwords: the address is {line, beat}.
   logic [63:0]        mem [DEPTH_LINES*4];

   logic [IDX_W-1:0]   live_line;
   logic               mem_we;
   logic               unused_addr;

   assign live_line   = pmem_address[5 +: IDX_W];
   assign unused_addr = ^(pmem_address & ~ADDR_USED_MASK);

   // A write beat commits at the edge that ends its resp cycle. Reset during
   // that cycle stops the commit, so the beats that remain keep their old data.
   assign mem_we = (state_q == S_BURST) && !op_rd_q && !rst;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[{line_q, beat_q}] <= pmem_wdata;
      end
   end

   // resp and rdata are loaded on the edge that enters each burst cycle.
   // This keeps both outputs purely registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         line_q  <= '0;
         op_rd_q <= 1'b0;
         cnt_q   <= '0;
         beat_q  <= '0;
         resp_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pmem_read || pmem_write) begin
                  line_q  <= live_line;
                  op_rd_q <= pmem_read;
                  cnt_q   <= CNT_LOAD;
                  beat_q  <= '0;
                  if (LATENCY == 1) begin
                     state_q <= S_BURST;
                     resp_q  <= 1'b1;
                     if (pmem_read) begin
                        rdata_q <= mem[{live_line, 2'b00}];
                     end
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // The counter reaches zero on the same edge that enters the
               // burst, so the first beat comes LATENCY cycles after acceptance.
               cnt_q <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_q <= S_BURST;
                  resp_q  <= 1'b1;
                  beat_q  <= '0;
                  if (op_rd_q) begin
                     rdata_q <= mem[{line_q, 2'b00}];
                  end
               end
            end
            S_BURST: begin
               if (beat_q == 2'd3) begin
                  state_q <= S_DONE;
                  resp_q  <= 1'b0;
                  beat_q  <= '0;
               end else begin
                  beat_q <= beat_q + 2'd1;
                  if (op_rd_q) begin
                     rdata_q <= mem[{line_q, beat_q + 2'd1}];
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign pmem_resp  = resp_q;
   assign pmem_rdata = rdata_q;

`ifdef PMEM_PROTO_CHECK_EN
   logic proto_q;
   logic viol;

   always_comb begin
      viol = 1'b0;
      if (state_q == S_IDLE) begin
         viol = pmem_read && pmem_write;
      end else if ((state_q == S_WAIT) || (state_q == S_BURST)) begin
         viol = (op_rd_q ? !pmem_read : !pmem_write) || (live_line != line_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         proto_q <= 1'b0;
      end else if (viol) begin
         proto_q <= 1'b1;
      end
   end

   assign proto_err = proto_q;
`endif

endmodule

// File: tb/tb_pmem_burst_responder.sv
// tb_pmem_burst_responder
//   Directed bench for pmem_burst_responder with DEPTH_LINES=256 and
//   LATENCY=4. The model keeps memory as qwords and records the expected resp
//   and read beats per cycle. Entries are added when each request is issued,
//   using the acceptance-cycle timing rule. One negedge process checks resp,
//   rdata (and proto_err when built) every cycle. Literal beat values fix
//   known points of the model.

module tb_pmem_burst_responder;

   localparam int DEPTH = 256;
   localparam int L     = 4;

   logic        clk;
   logic        rst;
   logic        pmem_read;
   logic        pmem_write;
   logic [31:0] pmem_address;
   logic [63:0] pmem_wdata;
   logic        pmem_resp;
   logic [63:0] pmem_rdata;
`ifdef PMEM_PROTO_CHECK_EN
   logic        proto_err;
`endif

   pmem_burst_responder #(
      .DEPTH_LINES(DEPTH),
      .LATENCY    (L)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pmem_read   (pmem_read),
      .pmem_write  (pmem_write),
      .pmem_address(pmem_address),
      .pmem_wdata  (pmem_wdata),
      .pmem_resp   (pmem_resp),
      .pmem_rdata  (pmem_rdata)
`ifdef PMEM_PROTO_CHECK_EN
      ,
      .proto_err   (proto_err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc      = 0;
   bit rst_prev = 1'b0;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_prev <= rst;
   end

   // Model state
   logic [63:0] mq [DEPTH*4];
   bit          mk [DEPTH*4];
   bit          exp_resp [int];
   logic [63:0] rd_val   [int];
   bit          rd_known [int];
   logic [63:0] lit      [int];
   logic [63:0] mrd    = '0;
   bit          mknown = 1'b1;
   int          proto_from = 32'h7fff_ffff;

   int checks = 0;
   int errors = 0;

   always @(negedge clk) begin
      if (cyc >= 1) begin
         bit er;
         er = exp_resp.exists(cyc);
         if (rst_prev) begin
            mrd    = '0;
            mknown = 1'b1;
         end
         if (er && rd_val.exists(cyc)) begin
            mrd    = rd_val[cyc];
            mknown = rd_known[cyc];
         end
         checks++;
         if (pmem_resp !== er) begin
            errors++;
            $display("FAIL resp cyc=%0d got %b want %b", cyc, pmem_resp, er);
         end
         if (mknown) begin
            checks++;
            if (pmem_rdata !== mrd) begin
               errors++;
               $display("FAIL rdata cyc=%0d got %h want %h", cyc, pmem_rdata, mrd);
            end
         end
         if (lit.exists(cyc)) begin
            checks++;
            if (pmem_rdata !== lit[cyc]) begin
               errors++;
               $display("FAIL lit_rdata cyc=%0d got %h want %h", cyc, pmem_rdata, lit[cyc]);
            end
         end
`ifdef PMEM_PROTO_CHECK_EN
         checks++;
         if (proto_err !== (cyc >= proto_from)) begin
            errors++;
            $display("FAIL proto_err cyc=%0d got %b want %b", cyc, proto_err, (cyc >= proto_from));
         end
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one line op from the current cycle. The current cycle must be idle,
   // or with early=1 the DONE cycle. The op returns in its DONE cycle.
   // abort_beat >= 0 asserts reset during that write beat's resp cycle.
   task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [255:0] wline, input bit early, input bit keep,
                        input int abort_beat, output int t_o);
      int t;
      int idx;
      logic [63:0] beat;
      pmem_read    = rd;
      pmem_write   = wr;
      pmem_address = addr;
      pmem_wdata   = {$urandom, $urandom};
      if (early) step();
      t   = cyc;
      t_o = t;
      idx = int'((addr >> 5) % DEPTH);
      for (int b = 0; b < 4; b++) begin
         if (abort_beat < 0 || b <= abort_beat) exp_resp[t+L+b] = 1'b1;
         if (rd) begin
            rd_val[t+L+b]   = mq[idx*4+b];
            rd_known[t+L+b] = mk[idx*4+b];
         end
      end
      for (int b = 0; b < 4; b++) begin
         while (cyc < t + L + b) step();
         if (wr) begin
            beat       = wline[64*b +: 64];
            pmem_wdata = beat;
            if (!rd) begin
               if (b == abort_beat) begin
                  rst = 1'b1;
                  step();
                  rst        = 1'b0;
                  pmem_read  = 1'b0;
                  pmem_write = 1'b0;
                  return;
               end
               mq[idx*4+b] = beat;
               mk[idx*4+b] = 1'b1;
            end
         end else begin
            pmem_wdata = {$urandom, $urandom};
         end
      end
      while (cyc < t + L + 4) step();
      if (!keep) begin
         pmem_read  = 1'b0;
         pmem_write = 1'b0;
      end
   endtask

   localparam logic [255:0] LINE_A = {64'h4444444444444444, 64'h3333333333333333,
                                      64'h2222222222222222, 64'h1111111111111111};
   localparam logic [255:0] LINE_5 = {4{64'h5555555555555555}};
   localparam logic [255:0] LINE_AA = {4{64'hAAAAAAAAAAAAAAAA}};
   localparam logic [255:0] LINE_X = {4{64'hDEADBEEFCAFEF00D}};

   initial begin
      int t;
      rst          = 1'b1;
      pmem_read    = 1'b1;
      pmem_write   = 1'b0;
      pmem_address = 32'h0000_0040;
      pmem_wdata   = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // A read held through reset is accepted in the first post-reset cycle.
      // The line has not been written yet, so its data is not checked.
      do_op(1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0, -1, t);
      step();

      do_op(1'b0, 1'b1, 32'h0000_0040, LINE_A, 1'b0, 1'b0, -1, t);
      step();

      lit[cyc+4] = 64'h1111111111111111;
      lit[cyc+5] = 64'h2222222222222222;
      lit[cyc+6] = 64'h3333333333333333;
      lit[cyc+7] = 64'h4444444444444444;
      do_op(1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0, -1, t);
      step();

      // Aliased read. The request stays high into DONE for a back-to-back read.
      lit[cyc+4] = 64'h1111111111111111;
      lit[cyc+7] = 64'h4444444444444444;
      do_op(1'b1, 1'b0, 32'h0000_2040, '0, 1'b0, 1'b1, -1, t);
      lit[t+13] = 64'h1111111111111111;
      lit[t+16] = 64'h4444444444444444;
      do_op(1'b1, 1'b0, 32'h0000_2040, '0, 1'b1, 1'b0, -1, t);
      step();

      do_op(1'b0, 1'b1, 32'h0000_0080, LINE_5, 1'b0, 1'b0, -1, t);
      step();
      do_op(1'b0, 1'b1, 32'h0000_0080, LINE_AA, 1'b0, 1'b0, 2, t);
      step();

      lit[cyc+4] = 64'hAAAAAAAAAAAAAAAA;
      lit[cyc+5] = 64'hAAAAAAAAAAAAAAAA;
      lit[cyc+6] = 64'h5555555555555555;
      lit[cyc+7] = 64'h5555555555555555;
      do_op(1'b1, 1'b0, 32'h0000_0080, '0, 1'b0, 1'b0, -1, t);
      step();

      // Read and write together: the read wins and the line is not changed.
`ifdef PMEM_PROTO_CHECK_EN
      proto_from = cyc + 1;
`endif
      lit[cyc+4] = 64'h1111111111111111;
      do_op(1'b1, 1'b1, 32'h0000_0040, LINE_X, 1'b0, 1'b0, -1, t);
      step();

      lit[cyc+4] = 64'h1111111111111111;
      lit[cyc+7] = 64'h4444444444444444;
      do_op(1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0, -1, t);
      step();
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
